jpeg_raster_writer: RTL and testbench

JPEG_RASTER_WRITER -- requirements
Module: jpeg_raster_writer

---
 rtl/jpeg_raster_writer.sv | 148 ++++++++++++++
 tb/tb_jpeg_raster_writer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_raster_writer.sv
// Converts 8x8-block raster rows into frame-buffer word writes with raster addressing,
// buffered through a small FIFO with sticky overflow and frame-position error flags.
`timescale 1ns/1ps
module jpeg_raster_writer #(
    parameter int unsigned WIDTH_BLOCKS  = 40,
    parameter int unsigned HEIGHT_BLOCKS = 30,
    parameter int unsigned ADDR_W        = 14,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [63:0]       row_in,
    input  logic              valid_in,
    input  logic              final_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [63:0]       wr_data_out,
    output logic              wr_en_out,
    input  logic              wr_ready_in,
    output logic              frame_done_out,
    output logic              overflow_out,
    output logic              error_out
);

    localparam int unsigned COL_W   = (WIDTH_BLOCKS > 1) ? $clog2(WIDTH_BLOCKS) : 1;
    localparam int unsigned ROW_W   = (HEIGHT_BLOCKS > 1) ? $clog2(HEIGHT_BLOCKS) : 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + 64 + 1;

    logic [2:0]         row_idx_q, row_idx_d;
    logic [COL_W-1:0]   col_blk_q, col_blk_d;
    logic [ROW_W-1:0]   row_blk_q, row_blk_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d, remaining;
    logic [ENTRY_W-1:0] head_q, head_d, push_entry;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic               wr_en_q, wr_en_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               error_q, error_d;
    logic               at_last, pop, push, full;
    logic [ADDR_W-1:0]  push_addr;

    // Position counters, address generation and frame-position checking
    always_comb begin
        row_idx_d = row_idx_q;
        col_blk_d = col_blk_q;
        row_blk_d = row_blk_q;
        error_d   = error_q;
        at_last   = (row_idx_q == 3'd7) &&
                    (col_blk_q == COL_W'(WIDTH_BLOCKS - 1)) &&
                    (row_blk_q == ROW_W'(HEIGHT_BLOCKS - 1));
        push_addr = ADDR_W'(((32'(row_blk_q) * 32'd8) + 32'(row_idx_q)) * WIDTH_BLOCKS
                            + 32'(col_blk_q));
        push_entry = {push_addr, row_in, at_last};
        if (valid_in) begin
            if (final_in && !at_last) begin
                // Early final: resynchronise so the next row opens a new frame
                row_idx_d = 3'd0;
                col_blk_d = '0;
                row_blk_d = '0;
                error_d   = 1'b1;
            end else begin
                if (!final_in && at_last) begin
                    error_d = 1'b1;
                end
                if (row_idx_q == 3'd7) begin
                    row_idx_d = 3'd0;
                    if (col_blk_q == COL_W'(WIDTH_BLOCKS - 1)) begin
                        col_blk_d = '0;
                        if (row_blk_q == ROW_W'(HEIGHT_BLOCKS - 1)) begin
                            row_blk_d = '0;
                        end else begin
                            row_blk_d = row_blk_q + ROW_W'(1);
                        end
                    end else begin
                        col_blk_d = col_blk_q + COL_W'(1);
                    end
                end else begin
                    row_idx_d = row_idx_q + 3'd1;
                end
            end
        end
    end

    // FIFO control; the head is mirrored into registers so outputs hold when empty
    always_comb begin
        pop        = wr_en_q && wr_ready_in;
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        push       = valid_in && (!full || pop);
        overflow_d = overflow_q || (valid_in && full && !pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        remaining  = count_q - CNT_W'(pop);
        head_d     = head_q;
        if (remaining != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push) begin
            head_d = push_entry;
        end
        wr_en_d = (count_d != '0);
        done_d  = pop && head_q[0];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            row_idx_q  <= 3'd0;
            col_blk_q  <= '0;
            row_blk_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            row_idx_q  <= row_idx_d;
            col_blk_q  <= col_blk_d;
            row_blk_q  <= row_blk_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    // Storage needs no reset: only slots covered by count_q are ever read
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign wr_addr_out    = head_q[ENTRY_W-1 -: ADDR_W];
    assign wr_data_out    = head_q[64:1];
    assign wr_en_out      = wr_en_q;
    assign frame_done_out = done_q;
    assign overflow_out   = overflow_q;
    assign error_out      = error_q;

endmodule

// File: tb/tb_jpeg_raster_writer.sv
// Directed bench: a 2x1-block instance for FIFO/flag behaviour and a default-size
// instance for full-frame addressing.
`timescale 1ns/1ps
module tb_jpeg_raster_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] row_s, row_b;
    logic        valid_s, fin_s, ready_s;
    logic        valid_b, fin_b, ready_b;
    logic [13:0] addr_s, addr_b;
    logic [63:0] data_s, data_b;
    logic        en_s, done_s, ovf_s, err_s;
    logic        en_b, done_b, ovf_b, err_b;

    int n_vec = 0;
    int n_err = 0;
    int done_s_cnt = 0;
    int done_b_cnt = 0;

    always #5 clk = ~clk;

    jpeg_raster_writer #(.WIDTH_BLOCKS(2), .HEIGHT_BLOCKS(1), .ADDR_W(14), .FIFO_DEPTH(4)) u_small (
        .clk_in(clk), .rst_in(rst_n), .row_in(row_s), .valid_in(valid_s), .final_in(fin_s),
        .wr_addr_out(addr_s), .wr_data_out(data_s), .wr_en_out(en_s), .wr_ready_in(ready_s),
        .frame_done_out(done_s), .overflow_out(ovf_s), .error_out(err_s)
    );

    jpeg_raster_writer u_big (
        .clk_in(clk), .rst_in(rst_n), .row_in(row_b), .valid_in(valid_b), .final_in(fin_b),
        .wr_addr_out(addr_b), .wr_data_out(data_b), .wr_en_out(en_b), .wr_ready_in(ready_b),
        .frame_done_out(done_b), .overflow_out(ovf_b), .error_out(err_b)
    );

    always @(negedge clk) begin
        if (done_s) done_s_cnt++;
        if (done_b) done_b_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one row ahead of the next rising edge, return 1 ns after it
    task automatic push_s(input logic [63:0] r, input logic f);
        @(negedge clk);
        row_s = r; valid_s = 1'b1; fin_s = f;
        @(posedge clk); #1;
        valid_s = 1'b0; fin_s = 1'b0;
    endtask

    task automatic push_b(input logic [63:0] r, input logic f);
        @(negedge clk);
        row_b = r; valid_b = 1'b1; fin_b = f;
        @(posedge clk); #1;
        valid_b = 1'b0; fin_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int got;
        int d0;
        logic [13:0] exp_a;
        rst_n = 1'b1;
        row_s = '0; valid_s = 1'b0; fin_s = 1'b0; ready_s = 1'b0;
        row_b = '0; valid_b = 1'b0; fin_b = 1'b0; ready_b = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", 64'(en_s), 64'd0);
        check("rst_addr", 64'(addr_s), 64'd0);
        check("rst_data", data_s, 64'd0);
        check("rst_done", 64'(done_s), 64'd0);
        check("rst_ovf", 64'(ovf_s), 64'd0);
        check("rst_err", 64'(err_s), 64'd0);
        check("rst_en_big", 64'(en_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full 2x1-block frame with a ready sink
        ready_s = 1'b1;
        d0 = done_s_cnt;
        for (int i = 0; i < 16; i++) begin
            exp_a = (i < 8) ? 14'(2 * i) : 14'(2 * (i - 8) + 1);
            push_s(64'h1111_0000_0000_0000 + 64'(i), (i == 15));
            check("frm_en", 64'(en_s), 64'd1);
            check("frm_addr", 64'(addr_s), 64'(exp_a));
            check("frm_data", data_s, 64'h1111_0000_0000_0000 + 64'(i));
            check("frm_done_low", 64'(done_s), 64'd0);
        end
        @(posedge clk); #1;
        check("frm_drained", 64'(en_s), 64'd0);
        check("frm_done", 64'(done_s), 64'd1);
        @(posedge clk); #1;
        check("frm_done_1cyc", 64'(done_s), 64'd0);
        check("frm_done_cnt", 64'(done_s_cnt - d0), 64'd1);
        check("frm_err", 64'(err_s), 64'd0);
        push_s(64'hABCD, 1'b0);
        check("frm_wrap_addr", 64'(addr_s), 64'd0);

        // Stalled sink: fifth row dropped
        do_reset();
        ready_s = 1'b0;
        for (int i = 0; i < 5; i++) push_s(64'h2200 + 64'(i), 1'b0);
        check("ovf_en", 64'(en_s), 64'd1);
        check("ovf_flag", 64'(ovf_s), 64'd1);
        check("ovf_head_addr", 64'(addr_s), 64'd0);
        check("ovf_head_data", data_s, 64'h2200);
        ready_s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ovf_drain_en", 64'(en_s), 64'd1);
            check("ovf_drain_addr", 64'(addr_s), 64'(2 * k));
        end
        @(negedge clk);
        check("ovf_row5_absent", 64'(en_s), 64'd0);
        check("ovf_sticky", 64'(ovf_s), 64'd1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        ready_s = 1'b0;
        for (int i = 0; i < 4; i++) push_s(64'h3300 + 64'(i), 1'b0);
        @(negedge clk);
        ready_s = 1'b1; row_s = 64'h3304; valid_s = 1'b1; fin_s = 1'b0;
        @(posedge clk); #1;
        valid_s = 1'b0; ready_s = 1'b0;
        check("full_pp_ovf", 64'(ovf_s), 64'd0);
        check("full_pp_head", 64'(addr_s), 64'd2);
        ready_s = 1'b1;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (en_s) begin
                check("full_pp_addr", 64'(addr_s), 64'(2 + 2 * got));
                got++;
            end
        end
        check("full_pp_occupancy", 64'(got), 64'd4);

        // Early final_in resynchronises the counters
        do_reset();
        ready_s = 1'b1;
        push_s(64'h4400, 1'b0);
        push_s(64'h4401, 1'b0);
        push_s(64'h4402, 1'b1);
        check("early_fin_addr", 64'(addr_s), 64'd4);
        check("early_fin_err", 64'(err_s), 64'd1);
        push_s(64'h4403, 1'b0);
        check("early_fin_next", 64'(addr_s), 64'd0);
        check("early_fin_nodone", 64'(done_s), 64'd0);

        // Missing final_in at the last position still flags and completes the frame
        do_reset();
        ready_s = 1'b1;
        for (int i = 0; i < 16; i++) push_s(64'h5500 + 64'(i), 1'b0);
        check("miss_fin_addr", 64'(addr_s), 64'd15);
        check("miss_fin_err", 64'(err_s), 64'd1);
        @(posedge clk); #1;
        check("miss_fin_done", 64'(done_s), 64'd1);

        // Short mid-cycle reset with entries buffered
        do_reset();
        ready_s = 1'b0;
        for (int i = 0; i < 3; i++) push_s(64'h6600 + 64'(i), 1'b0);
        check("arst_pre_en", 64'(en_s), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", 64'(en_s), 64'd0);
        check("arst_addr", 64'(addr_s), 64'd0);
        check("arst_data", data_s, 64'd0);
        #1 rst_n = 1'b1;
        ready_s = 1'b1;
        push_s(64'h6699, 1'b0);
        check("arst_first_en", 64'(en_s), 64'd1);
        check("arst_first_addr", 64'(addr_s), 64'd0);

        // Default-size frame: 30 x 40 blocks of 8 rows
        ready_b = 1'b1;
        d0 = done_b_cnt;
        for (int rb = 0; rb < 30; rb++) begin
            for (int cb = 0; cb < 40; cb++) begin
                for (int ri = 0; ri < 8; ri++) begin
                    push_b(64'((rb << 16) | (cb << 8) | ri), (rb == 29) && (cb == 39) && (ri == 7));
                    check("big_addr", 64'(addr_b), 64'((rb * 8 + ri) * 40 + cb));
                end
            end
        end
        check("big_final_addr", 64'(addr_b), 64'd9599);
        @(posedge clk); #1;
        check("big_done", 64'(done_b), 64'd1);
        @(posedge clk); #1;
        check("big_done_cnt", 64'(done_b_cnt - d0), 64'd1);
        check("big_err", 64'(err_b), 64'd0);
        check("big_ovf", 64'(ovf_b), 64'd0);
        push_b(64'h7777, 1'b0);
        check("big_wrap_addr", 64'(addr_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
